// File: rtl/iiitb_freqmeas_pkg.sv
// Shared types and constants for the iiitb_freqmeas frequency/duty meter.
package iiitb_freqmeas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  // Number of periods averaged per result when averaging is built in.
  localparam int unsigned AVG_N  = 4;
  localparam int unsigned AVG_SH = 2;

endpackage

// File: rtl/iiitb_freqmeas_if.sv
// Result port of iiitb_freqmeas: measured values, valid/ready handshake and status.
interface iiitb_freqmeas_if #(
  parameter int unsigned CNT_W = 16
);

  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             ready_i;
  logic             timeout_o;
  logic             overrun_o;

  modport master (
    output period_o, high_o, valid_o, timeout_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  period_o, high_o, valid_o, timeout_o, overrun_o,
    output ready_i
  );

endinterface

// File: rtl/iiitb_sync_edge.sv
// 2-flop synchronizer plus edge-detect flop for an asynchronous pad input.
// lvl is the synchronized level; rise/fall are single-cycle pulses.
module iiitb_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw input through the synchronizer and edge-detect stages.
  always_comb begin
    sync_d = {sync_q[1:0], d_i};
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign lvl  = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/iiitb_freqmeas.sv
// Frequency/duty meter: measures period and high time of sig_in in wb_clk_i
// cycles and presents each result on a valid/ready port.
// Optional build macro: IIITB_FREQMEAS_AVG_EN reports the average of 4 periods.
module iiitb_freqmeas
  import iiitb_freqmeas_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    en,
  input  logic                    sig_in,
  iiitb_freqmeas_if.master        res
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic sig_rise;
  logic sig_fall;
  logic sig_lvl_unused;

  iiitb_sync_edge u_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .d_i  (sig_in),
    .lvl  (sig_lvl_unused),
    .rise (sig_rise),
    .fall (sig_fall)
  );

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic [CNT_W-1:0] high_q,       high_d;
  logic             valid_q,      valid_d;
  logic             timeout_q,    timeout_d;
  logic             overrun_q,    overrun_d;

  logic [CNT_W-1:0] pc_inc;
  logic             done;
  logic             res_ok;
  logic [CNT_W-1:0] res_p;
  logic [CNT_W-1:0] res_h;

`ifdef IIITB_FREQMEAS_AVG_EN
  logic [CNT_W+AVG_SH-1:0] acc_p_q, acc_p_d;
  logic [CNT_W+AVG_SH-1:0] acc_h_q, acc_h_d;
  logic [AVG_SH-1:0]       acc_n_q, acc_n_d;
  logic [CNT_W+AVG_SH-1:0] sum_p;
  logic [CNT_W+AVG_SH-1:0] sum_h;
`endif

  assign pc_inc = period_cnt_q + CNT_ONE;

  // Measurement FSM, optional averaging and result/handshake next-state logic.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = valid_q;
    timeout_d    = 1'b0;
    overrun_d    = overrun_q;
    done         = 1'b0;
    res_ok       = 1'b0;
    res_p        = period_cnt_q;
    res_h        = high_cnt_q;

    if (valid_q && res.ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (en) begin
          state_d = ARM;
        end
      end
      // ARM also counts so a signal stuck at either level keeps timing out.
      ARM: begin
        if (sig_rise) begin
          state_d      = HIGH;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end else if (pc_inc == CNT_MAX) begin
          timeout_d    = 1'b1;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else begin
          period_cnt_d = pc_inc;
        end
      end
      HIGH: begin
        if (pc_inc == CNT_MAX) begin
          timeout_d    = 1'b1;
          state_d      = ARM;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else begin
          period_cnt_d = pc_inc;
          if (sig_fall) begin
            state_d = LOW;
          end else begin
            high_cnt_d = high_cnt_q + CNT_ONE;
          end
        end
      end
      LOW: begin
        if (sig_rise) begin
          done         = 1'b1;
          state_d      = HIGH;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end else if (pc_inc == CNT_MAX) begin
          timeout_d    = 1'b1;
          state_d      = ARM;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else begin
          period_cnt_d = pc_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Disable overrides everything except a result already pending.
    if (!en) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      timeout_d    = 1'b0;
      overrun_d    = 1'b0;
      done         = 1'b0;
    end

`ifdef IIITB_FREQMEAS_AVG_EN
    acc_p_d = acc_p_q;
    acc_h_d = acc_h_q;
    acc_n_d = acc_n_q;
    sum_p   = acc_p_q + {{AVG_SH{1'b0}}, period_cnt_q};
    sum_h   = acc_h_q + {{AVG_SH{1'b0}}, high_cnt_q};
    res_p   = sum_p[AVG_SH +: CNT_W];
    res_h   = sum_h[AVG_SH +: CNT_W];
    if (done) begin
      if (acc_n_q == AVG_SH'(AVG_N - 1)) begin
        res_ok  = 1'b1;
        acc_p_d = '0;
        acc_h_d = '0;
        acc_n_d = '0;
      end else begin
        acc_p_d = sum_p;
        acc_h_d = sum_h;
        acc_n_d = acc_n_q + 1'b1;
      end
    end
    if (!en || timeout_d) begin
      acc_p_d = '0;
      acc_h_d = '0;
      acc_n_d = '0;
    end
`else
    res_ok = done;
`endif

    // A completion is dropped only when the previous result is still unaccepted.
    if (res_ok) begin
      if (!valid_q || res.ready_i) begin
        period_d = res_p;
        high_d   = res_h;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef IIITB_FREQMEAS_AVG_EN
  // Averaging accumulators.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      acc_p_q <= '0;
      acc_h_q <= '0;
      acc_n_q <= '0;
    end else begin
      acc_p_q <= acc_p_d;
      acc_h_q <= acc_h_d;
      acc_n_q <= acc_n_d;
    end
  end
`endif

  assign res.period_o  = period_q;
  assign res.high_o    = high_q;
  assign res.valid_o   = valid_q;
  assign res.timeout_o = timeout_q;
  assign res.overrun_o = overrun_q;

endmodule

// File: doc/iiitb_freqmeas.md
# iiitb_freqmeas

Frequency/duty measurement block: counts the period and high time of a divided clock (the output of the team's frequency divider, or any slow digital signal on an IO pad) in units of `wb_clk_i` cycles. Results are presented on a valid/ready result port to the user-project wrapper or a logic-analyzer readout. It is the receive-side checker for the divider and lets firmware confirm the programmed divide ratio and duty on silicon.

## Interface
Parameters:
- `CNT_W`, 16: width of the period and high-time counters and results.

Ports:
- `wb_clk_i`  in  1  measurement clock; all logic on its rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `en`  in  1  measurement enable; low aborts and idles.
- `sig_in`  in  1  signal under test, asynchronous to `wb_clk_i`.
- `period_o`  out  CNT_W  measured period in clock cycles (rise to rise).
- `high_o`  out  CNT_W  measured high time in clock cycles (rise to fall).
- `valid_o`  out  1  result valid; held until accepted.
- `ready_i`  in  1  consumer accepts the result when `valid_o && ready_i`.
- `timeout_o`  out  1  one-cycle pulse when a counter saturates.
- `overrun_o`  out  1  sticky: a completed result was dropped; cleared by reset or by `en` low.

## Operation
- Input path: 2-flop synchronizer on `sig_in`, then a third flop for edge detect; `rise`/`fall` are single-cycle pulses.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: counters 0; `en`=1 -> ARM.
  - ARM: wait for `rise`; on `rise` -> HIGH, period_cnt=1, high_cnt=1.
  - HIGH: period_cnt++, high_cnt++; on `fall` -> LOW (high time frozen).
  - LOW: period_cnt++; on `rise` -> complete measurement, reload period_cnt=1, high_cnt=1, stay in HIGH path (back-to-back measurement, no lost period).
- `en`=0 in any state -> IDLE next cycle; in-progress counts discarded; an already pending result (`valid_o`=1) is kept; `overrun_o` cleared.
- Completion: `period_o`=period_cnt, `high_o`=high_cnt, `valid_o`=1.
  - If `valid_o`=1 and `ready_i`=0 at completion: result dropped, outputs unchanged, `overrun_o` set.
  - If `valid_o`=1 and `ready_i`=1 in the completion cycle: new result loaded, `valid_o` stays 1, no overrun.
- Saturation: when period_cnt reaches 2^CNT_W-1 in HIGH or LOW: `timeout_o` pulses, FSM -> ARM, no result produced. `sig_in` stuck at either level re-times out every 2^CNT_W-1 cycles.
- Reset: all outputs 0, FSM IDLE, synchronizer flops 0.

## Timing
- `sig_in` edge to `rise`/`fall` pulse: 3 clock cycles; this offset is identical for all edges, so measured widths are exact for signals synchronous to `wb_clk_i`, and ±1 cycle otherwise.
- `valid_o`, `period_o` and `high_o` are registered and update in the cycle after the `rise` that closes the period.
- Handshake: `valid_o` falls the cycle after `valid_o && ready_i`. `period_o` and `high_o` are stable while `valid_o`=1.
- Minimum measurable period is 2 cycles, with high time at least 1 cycle.

## Configuration
- `IIITB_FREQMEAS_AVG_EN` defined: each reported result is the average of 4 consecutive periods.
  - Accumulators are CNT_W+2 bits wide. Output is sum>>2, truncated.
  - The first result arrives after 4 full periods from ARM.
  - `en` low or a timeout clears the accumulator and the 4-period count.
- Macro undefined: every period is reported individually and no accumulator logic is present.

## Structure
- Shared package `iiitb_freqmeas_pkg` holds:
  - the FSM state enum (IDLE, ARM, HIGH, LOW);
  - the constant `AVG_N`=4 and its log2 `AVG_SH`=2.
- One sub-module, `iiitb_sync_edge`: 2-flop synchronizer plus edge detector; outputs `lvl`, `rise`, `fall`. It is reusable for other pad inputs.

## Test plan
- `sig_in` = divide-by-6 of `wb_clk_i` (3 high / 3 low), `ready_i`=1 -> every result is `period_o`=6, `high_o`=3; one result per 6 cycles and no overrun.
- Divide-by-5 (3 high / 2 low) -> `period_o`=5, `high_o`=3; with `IIITB_FREQMEAS_AVG_EN` the first valid result appears only after the 4th closing rise.
- `ready_i`=0 for 3 periods of divide-by-6 -> first result held unchanged and `overrun_o`=1; then `ready_i`=1 -> `valid_o` drops the cycle after acceptance, and the next completion loads fresh values.
- `CNT_W`=8, `sig_in` held high after one rise -> `timeout_o` pulses 254 cycles after entering HIGH (count 1→255), FSM returns to ARM, and `valid_o` stays 0.
- `en` dropped mid-HIGH, then raised -> the partial period is discarded; the first result is from a full period after the next rise and has correct values.
- `wb_rst_i` asserted while `valid_o`=1 and `overrun_o`=1 -> the next cycle all outputs are 0 and the FSM is IDLE.
